// File: rtl/switch_arbiter.sv
// Round-robin arbiter/sequencer for the 2-to-2 switch: grants bursts and drives the selects.
// Optional bus-release cycle after each burst when SW_ARB_TURNAROUND_EN is defined.
module switch_arbiter #(
    parameter int unsigned LEN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 dest0,
    input  logic                 dest1,
    input  logic [LEN_WIDTH-1:0] len0,
    input  logic [LEN_WIDTH-1:0] len1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 in_select,
    output logic                 out_select,
    output logic                 xfer_valid,
    output logic                 last,
    output logic                 busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StTurn  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rr_q, rr_d;
    logic                 gnt0_q, gnt0_d;
    logic                 gnt1_q, gnt1_d;
    logic                 in_sel_q, in_sel_d;
    logic                 out_sel_q, out_sel_d;
    logic                 xfer_q, xfer_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;

    logic                 decide;
    logic                 any_req;
    logic                 winner;
    logic                 win_dest;
    logic [LEN_WIDTH-1:0] win_len;

    // Contention goes to the rr pointer; otherwise the lone requester wins.
    always_comb begin
        any_req  = req0 | req1;
        winner   = (req0 & req1) ? rr_q : req1;
        win_dest = winner ? dest1 : dest0;
        win_len  = winner ? len1 : len0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
        xfer_d    = 1'b0;
        last_d    = 1'b0;
        busy_d    = 1'b0;
        decide    = 1'b0;

        unique case (state_q)
            StIdle: begin
                decide = 1'b1;
            end
            StBurst: begin
                if (last_q) begin
`ifdef SW_ARB_TURNAROUND_EN
                    state_d = StTurn;
                    busy_d  = 1'b1;
`else
                    decide  = 1'b1;
`endif
                end else begin
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                    last_d = (cnt_q == LEN_WIDTH'(1));
                    gnt0_d = gnt0_q;
                    gnt1_d = gnt1_q;
                    xfer_d = 1'b1;
                    busy_d = 1'b1;
                end
            end
`ifdef SW_ARB_TURNAROUND_EN
            StTurn: begin
                decide = 1'b1;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        if (decide) begin
            if (any_req) begin
                state_d   = StBurst;
                cnt_d     = win_len;
                rr_d      = ~winner;
                gnt0_d    = ~winner;
                gnt1_d    = winner;
                in_sel_d  = winner;
                out_sel_d = win_dest;
                xfer_d    = 1'b1;
                last_d    = (win_len == '0);
                busy_d    = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rr_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            in_sel_q  <= 1'b0;
            out_sel_q <= 1'b0;
            xfer_q    <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            in_sel_q  <= in_sel_d;
            out_sel_q <= out_sel_d;
            xfer_q    <= xfer_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign in_select  = in_sel_q;
    assign out_select = out_sel_q;
    assign xfer_valid = xfer_q;
    assign last       = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Self-checking bench for switch_arbiter: directed scenarios plus randomized traffic
// against a beats-remaining transaction model.
module tb_switch_arbiter;

    localparam int LW = 4;

`ifdef SW_ARB_TURNAROUND_EN
    localparam bit HasTurn = 1'b1;
`else
    localparam bit HasTurn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          dest0 = 1'b0, dest1 = 1'b0;
    logic [LW-1:0] len0 = '0, len1 = '0;
    logic          gnt0, gnt1, in_select, out_select, xfer_valid, last, busy;

    always #5 clk = ~clk;

    switch_arbiter #(.LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .dest0      (dest0),
        .dest1      (dest1),
        .len0       (len0),
        .len1       (len1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .in_select  (in_select),
        .out_select (out_select),
        .xfer_valid (xfer_valid),
        .last       (last),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the switch and how many beats of its burst remain (incl. current).
    int m_owner = -1;
    int m_left  = 0;
    int m_rr    = 0;
    bit m_turn  = 1'b0;
    bit m_in    = 1'b0;
    bit m_out   = 1'b0;

    task automatic model_step();
        if (reset) begin
            m_owner = -1; m_left = 0; m_rr = 0; m_turn = 1'b0; m_in = 1'b0; m_out = 1'b0;
        end else if (m_owner >= 0 && m_left > 1) begin
            m_left--;
        end else if (m_owner >= 0 && HasTurn) begin
            m_owner = -1;
            m_turn  = 1'b1;
        end else begin
            m_turn = 1'b0;
            if (req0 || req1) begin
                int w;
                w       = (req0 && req1) ? m_rr : (req1 ? 1 : 0);
                m_owner = w;
                m_left  = (w == 1 ? int'(len1) : int'(len0)) + 1;
                m_in    = (w == 1);
                m_out   = (w == 1) ? dest1 : dest0;
                m_rr    = 1 - w;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    function automatic logic [6:0] exp_vec();
        return {m_owner == 0, m_owner == 1, m_in, m_out, m_owner >= 0,
                m_owner >= 0 && m_left == 1, m_owner >= 0 || m_turn};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {gnt0, gnt1, in_select, out_select, xfer_valid, last, busy};
    endfunction

    // Advance one clock: model takes the edge, outputs are then sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs_vec() !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_values: got %b want %b", obs_vec(), 7'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        int beats = 0;
        int last_at = -1;
        req0 = 1'b1; dest0 = 1'b1; len0 = 4'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt0) req0 = 1'b0;
            if (xfer_valid) beats++;
            if (last) last_at = beats;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL single[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (beats !== 3 || last_at !== 3) begin
            n_bad++;
            $display("FAIL single_len: got beats=%0d last_at=%0d want 3/3", beats, last_at);
        end
    endtask

    task automatic test_contention();
        int owners[$];
        req0 = 1'b1; req1 = 1'b1; len0 = '0; len1 = '0; dest0 = 1'b0; dest1 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt0) owners.push_back(0);
            if (gnt1) owners.push_back(1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL contention[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (owners.size() < 4) begin
            n_bad++;
            $display("FAIL contention_count: got %0d grants want >=4", owners.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (owners[k] !== k % 2) begin
                    n_bad++;
                    $display("FAIL contention_order[%0d]: got %0d want %0d", k, owners[k], k % 2);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL contention_drain[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int t_last0 = -100;
        int t_first1 = -100;
        req0 = 1'b1; dest0 = 1'b0; len0 = 4'd3;
        len1 = 4'd1; dest1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gnt0) req0 = 1'b0;
            if (i == 1) req1 = 1'b1;
            if (gnt0 && last) t_last0 = i;
            if (gnt1 && t_first1 < 0) begin
                t_first1 = i;
                req1 = 1'b0;
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (t_first1 - t_last0 !== 1 + int'(HasTurn)) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d want %0d", t_first1 - t_last0, 1 + int'(HasTurn));
        end
    endtask

    task automatic test_max_len();
        int beats = 0;
        int lasts = 0;
        int last_at = -1;
        req0 = 1'b1; dest0 = 1'b1; len0 = 4'd15;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (gnt0) req0 = 1'b0;
            if (xfer_valid) beats++;
            if (last) begin
                lasts++;
                last_at = beats;
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL maxlen[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (beats !== 16 || lasts !== 1 || last_at !== 16) begin
            n_bad++;
            $display("FAIL maxlen_beats: got beats=%0d lasts=%0d last_at=%0d want 16/1/16",
                     beats, lasts, last_at);
        end
    endtask

    task automatic test_stability();
        int beats = 0;
        bit moved = 1'b0;
        req0 = 1'b1; dest0 = 1'b0; len0 = 4'd4;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (gnt0) begin
                req0 = 1'b0; dest0 = 1'b1; len0 = 4'd1;
            end
            if (xfer_valid) begin
                beats++;
                if (out_select !== 1'b0) moved = 1'b1;
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stability[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (beats !== 5 || moved) begin
            n_bad++;
            $display("FAIL stability_burst: got beats=%0d moved=%0d want 5/0", beats, moved);
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; dest0 = 1'b1; len0 = 4'd7;
        tick();
        req0 = 1'b0;
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid_beat2: got %b want %b", obs_vec(), exp_vec());
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs_vec() !== 7'b0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got %b want %b", obs_vec(), 7'b0);
        end
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 4'd1; len1 = 4'd0;
        tick();
        req0 = 1'b0;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid_first_grant: got %b want %b", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt1) req1 = 1'b0;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstmid_after[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            dest0 = 1'($urandom);
            dest1 = 1'($urandom);
            len0  = ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'($urandom_range(0, 2));
            len1  = ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'($urandom_range(0, 2));
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_max_len();
        test_stability();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
